// File: rtl/gshare_predictor_pkg.sv
// Shared types and helpers for the gshare/gselect direction predictor.
// Lookup and training both index through pht_index so the two paths always agree.
package gshare_predictor_pkg;

  localparam int unsigned CTR_MAX_BITS = 4;

  typedef enum int unsigned {
    HASH_GSELECT = 0,
    HASH_GSHARE  = 1
  } hash_mode_e;

  function automatic logic [CTR_MAX_BITS-1:0] weak_not_taken(int unsigned ctr_bits);
    return CTR_MAX_BITS'((1 << (ctr_bits - 1)) - 1);
  endfunction

  function automatic logic [CTR_MAX_BITS-1:0] ctr_update(logic [CTR_MAX_BITS-1:0] ctr,
                                                        logic taken,
                                                        int unsigned ctr_bits);
    logic [CTR_MAX_BITS-1:0] ctr_max;
    ctr_max = CTR_MAX_BITS'((1 << ctr_bits) - 1);
    if (taken) return (ctr == ctr_max) ? ctr : ctr + 1'b1;
    return (ctr == '0) ? ctr : ctr - 1'b1;
  endfunction

  // ghr arrives zero-extended and is always below 2^hist_bits.
  function automatic logic [31:0] pht_index(logic [31:0] pc, logic [31:0] ghr,
                                            int unsigned index_bits,
                                            int unsigned hist_bits,
                                            hash_mode_e mode);
    logic [31:0] pc_bits;
    pc_bits = (pc >> 2) & ((32'd1 << index_bits) - 32'd1);
    if (mode == HASH_GSELECT) return (pc_bits << hist_bits) | ghr;
    return pc_bits ^ ghr;
  endfunction

endpackage

// File: rtl/gshare_predictor_if.sv
// Fetch lookup and decode training signals of the branch predictor.
interface gshare_predictor_if;
  logic [31:0] instructionPC;
  logic [31:0] PCD;
  logic [31:0] branchTargetD;
  logic        isBranch;
  logic        branchTaken;
  logic        branchstall;
  logic [31:0] predictedPC;
  logic        prediction;
  logic        btbHit;

  modport master (
    output instructionPC, PCD, branchTargetD, isBranch, branchTaken, branchstall,
    input  predictedPC, prediction, btbHit
  );

  modport slave (
    input  instructionPC, PCD, branchTargetD, isBranch, branchTaken, branchstall,
    output predictedPC, prediction, btbHit
  );
endinterface

// File: rtl/gshare_predictor_branch_target_table.sv
// Direct-mapped tagged branch target buffer: async valid clear, combinational
// read, synchronous write. Addresses are word addresses (PC[31:2]).
module branch_target_table #(
  parameter int unsigned INDEX_BITS = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [29:0] lookup_word,
  output logic        hit,
  output logic [31:0] target,
  input  logic        write_en,
  input  logic [29:0] write_word,
  input  logic [31:0] write_target
);

  localparam int unsigned DEPTH    = 1 << INDEX_BITS;
  localparam int unsigned TAG_BITS = 30 - INDEX_BITS;

  logic                valid   [DEPTH];
  logic [TAG_BITS-1:0] tags    [DEPTH];
  logic [31:0]         targets [DEPTH];

  logic [INDEX_BITS-1:0] lookup_idx;
  logic [TAG_BITS-1:0]   lookup_tag;
  logic [INDEX_BITS-1:0] write_idx;
  logic [TAG_BITS-1:0]   write_tag;

  assign lookup_idx = lookup_word[INDEX_BITS-1:0];
  assign lookup_tag = lookup_word[29:INDEX_BITS];
  assign write_idx  = write_word[INDEX_BITS-1:0];
  assign write_tag  = write_word[29:INDEX_BITS];

  assign hit    = valid[lookup_idx] && (tags[lookup_idx] == lookup_tag);
  assign target = targets[lookup_idx];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) valid[i] <= 1'b0;
    end else if (write_en) begin
      valid[write_idx] <= 1'b1;
    end
  end

  // Payload needs no reset: it is only observed through a set valid bit.
  always_ff @(posedge clk) begin
    if (write_en) begin
      tags[write_idx]    <= write_tag;
      targets[write_idx] <= write_target;
    end
  end

endmodule

// File: rtl/gshare_predictor.sv
// Global-history direction predictor (gshare or gselect indexing) with an
// integrated tagged BTB; combinational fetch lookup, decode-stage training.
module gshare_predictor
  import gshare_predictor_pkg::*;
#(
  parameter int unsigned INDEX_BITS     = 6,
  parameter int unsigned HIST_BITS      = 2,
  parameter int unsigned CTR_BITS       = 2,
  parameter int unsigned HASH_MODE      = 1,
  parameter int unsigned BTB_INDEX_BITS = 6
) (
  input logic              clk,
  input logic              reset,
  gshare_predictor_if.slave bus
);

  localparam hash_mode_e  MODE      = hash_mode_e'(HASH_MODE);
  localparam int unsigned PHT_BITS  = (MODE == HASH_GSELECT) ? INDEX_BITS + HIST_BITS : INDEX_BITS;
  localparam int unsigned PHT_DEPTH = 1 << PHT_BITS;

  logic [CTR_BITS-1:0]  pht [PHT_DEPTH];
  logic [HIST_BITS-1:0] ghr;
  logic [HIST_BITS-1:0] ghr_next;
  logic [PHT_BITS-1:0]  lookup_idx;
  logic [PHT_BITS-1:0]  train_idx;
  logic                 train;
  logic                 btb_hit;
  logic [31:0]          btb_target;
  logic                 taken_pred;

  assign train      = bus.isBranch && !bus.branchstall;
  assign lookup_idx = PHT_BITS'(pht_index(bus.instructionPC, 32'(ghr), INDEX_BITS, HIST_BITS, MODE));
  assign train_idx  = PHT_BITS'(pht_index(bus.PCD, 32'(ghr), INDEX_BITS, HIST_BITS, MODE));

  // Shift-then-overwrite form stays legal when HIST_BITS is 1.
  always_comb begin
    ghr_next              = ghr >> 1;
    ghr_next[HIST_BITS-1] = bus.branchTaken;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < PHT_DEPTH; i++) pht[i] <= CTR_BITS'(weak_not_taken(CTR_BITS));
      ghr <= '0;
    end else if (train) begin
      pht[train_idx] <= CTR_BITS'(ctr_update(CTR_MAX_BITS'(pht[train_idx]), bus.branchTaken, CTR_BITS));
      ghr            <= ghr_next;
    end
  end

  branch_target_table #(
    .INDEX_BITS(BTB_INDEX_BITS)
  ) u_btb (
    .clk          (clk),
    .reset        (reset),
    .lookup_word  (bus.instructionPC[31:2]),
    .hit          (btb_hit),
    .target       (btb_target),
    .write_en     (train && bus.branchTaken),
    .write_word   (bus.PCD[31:2]),
    .write_target (bus.branchTargetD)
  );

  assign taken_pred      = pht[lookup_idx][CTR_BITS-1] && btb_hit;
  assign bus.prediction  = taken_pred;
  assign bus.btbHit      = btb_hit;
  assign bus.predictedPC = taken_pred ? btb_target : bus.instructionPC + 32'd4;

endmodule
